// File: rtl/seq_nibble_adder_ctrl_pkg.sv
// Shared state encoding and slice width for the sequential nibble adder.
package seq_nibble_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_nibble_adder_ctrl_nibble_adder4.sv
// Combinational 4-bit adder with carry in/out, behaving like a 74HC283.
module nibble_adder4
  import seq_nibble_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] total_s;

  // Five-bit sum; the top bit is the carry out of the slice.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
  end

  assign s  = total_s[NIBBLE_W-1:0];
  assign co = total_s[NIBBLE_W];

endmodule

// File: rtl/seq_nibble_adder_ctrl.sv
// Sequencer that computes one wide add/subtract by reusing a single 4-bit
// adder once per clock, least-significant nibble first.
module seq_nibble_adder_ctrl
  import seq_nibble_adder_ctrl_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Start,
  input  logic                          Sub,
  input  logic                          Cin,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] DataA,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] DataB,
  output logic                          Busy,
  output logic                          Done,
  output logic [NIBBLE_W*N_NIBBLES-1:0] Sum,
  output logic                          Cout,
  output logic                          Ovf
);

  localparam int W  = NIBBLE_W * N_NIBBLES;
  localparam int RW = W - NIBBLE_W;
  localparam int CW = $clog2(N_NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_NIBBLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [RW-1:0]   res_q, res_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]          b_in_s;
  logic [NIBBLE_W-1:0]   nib_sum_s;
  logic                  nib_co_s;

  nibble_adder4 u_adder (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (nib_sum_s),
    .co (nib_co_s)
  );

  // Operand B as presented to the adder: inverted for subtraction.
  always_comb begin
    if (Sub) begin
      b_in_s = ~DataB;
    end else begin
      b_in_s = DataB;
    end
  end

  // Next-state and datapath updates; every register holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d      = DataA;
          b_d      = b_in_s;
          carry_d  = Sub ? 1'b1 : Cin;
          sign_a_d = DataA[W-1];
          sign_b_d = b_in_s[W-1];
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Each nibble enters at the top so the first one ends up in the LSBs.
        res_d   = RW'({nib_sum_s, res_q} >> NIBBLE_W);
        carry_d = nib_co_s;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        if (cnt_q == LAST_CNT) begin
          sum_d   = {nib_sum_s, res_q};
          cout_d  = nib_co_s;
          ovf_d   = (sign_a_q == sign_b_q) && (nib_sum_s[NIBBLE_W-1] != sign_a_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_nibble_adder_ctrl.sv
// Directed self-checking bench for seq_nibble_adder_ctrl with N_NIBBLES=4.
module tb_seq_nibble_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic         Sub;
  logic         Cin;
  logic [W-1:0] DataA;
  logic [W-1:0] DataB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  seq_nibble_adder_ctrl #(.N_NIBBLES(N)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Sub   (Sub),
    .Cin   (Cin),
    .DataA (DataA),
    .DataB (DataB),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  // Hand-computed vectors: A, B, Sub, Cin -> Sum, Cout, Ovf
  localparam int NV = 7;
  localparam logic [W-1:0] VA   [NV] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h0005, 16'h8000};
  localparam logic [W-1:0] VB   [NV] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0001, 16'h0007, 16'h0007, 16'h0001};
  localparam logic         VSUB [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic         VCIN [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [W-1:0] VSUM [NV] = '{16'h2233, 16'h0000, 16'h0000, 16'h8000, 16'hFFFE, 16'hFFFE, 16'h7FFF};
  localparam logic         VCO  [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic         VOV  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for exactly one edge, then scramble the operand inputs.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub, input logic cin);
    Start = 1'b1;
    DataA = a;
    DataB = b;
    Sub   = sub;
    Cin   = cin;
    tick();
    Start = 1'b0;
    DataA = W'($urandom);
    DataB = W'($urandom);
    Sub   = 1'($urandom);
    Cin   = 1'($urandom);
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; DataA = '0; DataB = '0;
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({Busy, Done, Sum, Cout, Ovf} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: Busy=%b Done=%b Sum=%h Cout=%b Ovf=%b, required all zero",
                 c, Busy, Done, Sum, Cout, Ovf);
      end
      tick();
    end
  endtask

  task automatic test_arith();
    for (int v = 0; v < NV; v++) begin
      drive_start(VA[v], VB[v], VSUB[v], VCIN[v]);
      for (int c = 0; c < N; c++) begin
        n_checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
          n_fail++;
          $display("FAIL arith_busy[%0d] cycle %0d: Busy=%b Done=%b, required Busy=1 Done=0",
                   v, c, Busy, Done);
        end
        tick();
      end
      n_checks++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_done[%0d]: Done=%b Busy=%b, required Done=1 Busy=0", v, Done, Busy);
      end
      n_checks++;
      if (Sum !== VSUM[v]) begin
        n_fail++;
        $display("FAIL arith_sum[%0d]: got %h, required %h", v, Sum, VSUM[v]);
      end
      n_checks++;
      if (Cout !== VCO[v]) begin
        n_fail++;
        $display("FAIL arith_cout[%0d]: got %b, required %b", v, Cout, VCO[v]);
      end
      n_checks++;
      if (Ovf !== VOV[v]) begin
        n_fail++;
        $display("FAIL arith_ovf[%0d]: got %b, required %b", v, Ovf, VOV[v]);
      end
      tick();
      tick();
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== VSUM[v]) begin
        n_fail++;
        $display("FAIL arith_hold[%0d]: Done=%b Busy=%b Sum=%h, required Done=0 Busy=0 Sum=%h",
                 v, Done, Busy, Sum, VSUM[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1; DataA = 16'h1111; DataB = 16'h0101; Sub = 1'b0; Cin = 1'b0;
    tick();
    for (int c = 0; c < N; c++) begin
      DataA = W'($urandom); DataB = W'($urandom); Sub = 1'($urandom); Cin = 1'($urandom);
      n_checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_busy cycle %0d: Busy=%b Done=%b, required Busy=1 Done=0", c, Busy, Done);
      end
      tick();
    end
    n_checks++;
    if (Done !== 1'b1 || Sum !== 16'h1212 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: Done=%b Sum=%h Cout=%b Ovf=%b, required Done=1 Sum=1212 Cout=0 Ovf=0",
               Done, Sum, Cout, Ovf);
    end
    DataA = 16'h5555; DataB = 16'h5555;
    tick();
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: Busy=%b Done=%b, required Busy=0 Done=0", Busy, Done);
    end
    DataA = 16'h0102; DataB = 16'h0304; Sub = 1'b0; Cin = 1'b0;
    tick();
    Start = 1'b0;
    for (int c = 0; c < N; c++) begin
      n_checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_second_busy cycle %0d: Busy=%b Done=%b, required Busy=1 Done=0",
                 c, Busy, Done);
      end
      tick();
    end
    n_checks++;
    if (Done !== 1'b1 || Sum !== 16'h0406) begin
      n_fail++;
      $display("FAIL b2b_second: Done=%b Sum=%h, required Done=1 Sum=0406", Done, Sum);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    drive_start(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if ({Busy, Done, Sum, Cout, Ovf} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset: Busy=%b Done=%b Sum=%h Cout=%b Ovf=%b, required all zero",
               Busy, Done, Sum, Cout, Ovf);
    end
    for (int c = 0; c < N + 2; c++) begin
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_no_done cycle %0d: Done=%b Busy=%b, required 0 0", c, Done, Busy);
      end
      tick();
    end
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int c = 0; c < N; c++) begin
      tick();
    end
    n_checks++;
    if (Done !== 1'b1 || Sum !== 16'h3333 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_fresh: Done=%b Sum=%h Cout=%b Ovf=%b, required Done=1 Sum=3333 Cout=0 Ovf=0",
               Done, Sum, Cout, Ovf);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
